// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the alu operand-issue stage.
//   DW     - default datapath width, matches the downstream alu
//   CMD_W  - alu command width
//   state_e - issue controller FSM encoding
package alu_pkg;
  localparam int DW    = 8;
  localparam int CMD_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_e;
endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: NREG x DW operand register file.
//   clk, rst            - clock, synchronous active-high reset (clears all entries)
//   wr_en/addr/data     - single synchronous write port
//   rd_addr_a/rd_data_a - combinational read port feeding alu a
//   rd_addr_b/rd_data_b - combinational read port feeding alu b
module alu_regfile #(
  parameter int DW   = alu_pkg::DW,
  parameter int NREG = 4,
  parameter int AW   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr_a,
  output logic [DW-1:0] rd_data_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [DW-1:0] rd_data_b
);

  logic [DW-1:0] mem_q [NREG];
  logic [DW-1:0] mem_d [NREG];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data_a = mem_q[rd_addr_a];
  assign rd_data_b = mem_q[rd_addr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: operand-issue stage in front of the 8-bit combinational alu.
// Holds the operand register file, accepts one op at a time over in_valid/in_ready,
// drives the alu from registered operands, captures y/z/c, writes y back to rd and
// presents the result over out_valid/out_ready.
//   clk, rst                  - clock, synchronous active-high reset
//   ld_en/ld_addr/ld_data     - register-file load (honoured only in IDLE, wins over in_valid)
//   in_valid/in_ready         - op request handshake; in_cmd/in_rd/in_rs1/in_rs2 op fields
//   alu_a/alu_b/alu_cmd       - registered alu operands (hold last value after the op)
//   alu_y/alu_z/alu_c         - alu result inputs
//   out_valid/out_ready       - result handshake; out_data/out_z/out_c captured result
//   op_count                  - completed-op counter, saturating (only with ALU_OP_COUNT_EN)
//   busy                      - high whenever the FSM is not in IDLE
// Build option: define ALU_OP_COUNT_EN to add the op_count output.
//
// state   | meaning
// IDLE    | accepting loads or a new op request
// ISSUE   | alu operands stable; result captured and written back at the edge
// CAPTURE | result registered; raise out_valid
// RESP    | hold result until out_ready
module alu_issue_ctrl #(
  parameter int DW   = alu_pkg::DW,
  parameter int NREG = 4,
  parameter int AW   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ld_en,
  input  logic [AW-1:0]             ld_addr,
  input  logic [DW-1:0]             ld_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [alu_pkg::CMD_W-1:0] in_cmd,
  input  logic [AW-1:0]             in_rd,
  input  logic [AW-1:0]             in_rs1,
  input  logic [AW-1:0]             in_rs2,
  output logic [DW-1:0]             alu_a,
  output logic [DW-1:0]             alu_b,
  output logic [alu_pkg::CMD_W-1:0] alu_cmd,
  input  logic [DW-1:0]             alu_y,
  input  logic                      alu_z,
  input  logic                      alu_c,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DW-1:0]             out_data,
  output logic                      out_z,
  output logic                      out_c,
`ifdef ALU_OP_COUNT_EN
  output logic [7:0]                op_count,
`endif
  output logic                      busy
);
  import alu_pkg::*;

  state_e            state_q, state_d;
  logic [DW-1:0]     alu_a_q, alu_a_d;
  logic [DW-1:0]     alu_b_q, alu_b_d;
  logic [CMD_W-1:0]  alu_cmd_q, alu_cmd_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic              out_valid_q, out_valid_d;
  logic [DW-1:0]     out_data_q, out_data_d;
  logic              out_z_q, out_z_d;
  logic              out_c_q, out_c_d;

  logic              rf_wr_en;
  logic [AW-1:0]     rf_wr_addr;
  logic [DW-1:0]     rf_wr_data;
  logic [DW-1:0]     rf_rd_a, rf_rd_b;

  // Write port is shared: loads in IDLE, alu write-back in ISSUE.
  alu_regfile #(.DW(DW), .NREG(NREG), .AW(AW)) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (rf_wr_en),
    .wr_addr   (rf_wr_addr),
    .wr_data   (rf_wr_data),
    .rd_addr_a (in_rs1),
    .rd_data_a (rf_rd_a),
    .rd_addr_b (in_rs2),
    .rd_data_b (rf_rd_b)
  );

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_cmd_d   = alu_cmd_q;
    rd_d        = rd_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_z_d     = out_z_q;
    out_c_d     = out_c_q;
    rf_wr_en    = 1'b0;
    rf_wr_addr  = ld_addr;
    rf_wr_data  = ld_data;

    case (state_q)
      IDLE: begin
        if (ld_en) begin
          rf_wr_en = 1'b1;
        end else if (in_valid) begin
          alu_a_d   = rf_rd_a;
          alu_b_d   = rf_rd_b;
          alu_cmd_d = in_cmd;
          rd_d      = in_rd;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        out_data_d = alu_y;
        out_z_d    = alu_z;
        out_c_d    = alu_c;
        rf_wr_en   = 1'b1;
        rf_wr_addr = rd_q;
        rf_wr_data = alu_y;
        state_d    = CAPTURE;
      end
      CAPTURE: begin
        out_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_cmd_q   <= '0;
      rd_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_z_q     <= 1'b0;
      out_c_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_cmd_q   <= alu_cmd_d;
      rd_q        <= rd_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_z_q     <= out_z_d;
      out_c_q     <= out_c_d;
    end
  end

`ifdef ALU_OP_COUNT_EN
  logic [7:0] op_count_q, op_count_d;

  always_comb begin
    op_count_d = op_count_q;
    if (state_q == RESP && out_valid_q && out_ready && op_count_q != 8'hFF)
      op_count_d = op_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) op_count_q <= '0;
    else     op_count_q <= op_count_d;
  end

  assign op_count = op_count_q;
`endif

  // A load in IDLE takes the cycle, so the request is held off until it clears.
  assign in_ready  = (state_q == IDLE) && !ld_en;
  assign busy      = (state_q != IDLE);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_cmd   = alu_cmd_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_z     = out_z_q;
  assign out_c     = out_c_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: scoreboard bench for alu_issue_ctrl with a stub alu
// (cmd 000 = add with carry-out, others = xor; z = y==0).
module tb_alu_issue_ctrl;
  localparam int DW = 8;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_cmd;
  logic [AW-1:0] in_rd, in_rs1, in_rs2;
  logic [DW-1:0] alu_a, alu_b, alu_y;
  logic [2:0]    alu_cmd;
  logic          alu_z, alu_c;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic          out_z, out_c;
  logic          busy;
`ifdef ALU_OP_COUNT_EN
  logic [7:0]    op_count;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int hs_cnt = 0;
  logic [9:0]    sb_q[$];
  logic [DW-1:0] model_rf [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_issue_ctrl #(.DW(DW), .NREG(4), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd),
    .alu_y(alu_y), .alu_z(alu_z), .alu_c(alu_c),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_z(out_z), .out_c(out_c),
`ifdef ALU_OP_COUNT_EN
    .op_count(op_count),
`endif
    .busy(busy)
  );

  // returns {c, z, y}
  function automatic logic [9:0] alu_model(input logic [2:0] cmd, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    if (cmd == 3'b000) s = {1'b0, a} + {1'b0, b};
    else               s = {1'b0, a ^ b};
    return {s[8], (s[7:0] == 8'h00), s[7:0]};
  endfunction

  logic [9:0] stub_res;
  always_comb begin
    stub_res = alu_model(alu_cmd, alu_a, alu_b);
    alu_c = stub_res[9];
    alu_z = stub_res[8];
    alu_y = stub_res[7:0];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Result monitor: a handshake will occur at the coming edge.
  always begin
    @(negedge clk);
    #2;
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_nonempty", sb_q.size(), 1);
      end else begin
        check("sb_result", {out_c, out_z, out_data}, sb_q.pop_front());
      end
      hs_cnt++;
    end
  end

  task automatic do_load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
    model_rf[a] = d;
  endtask

  task automatic wait_idle();
    int w = 0;
    while (busy && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("idle_wait", busy, 0);
  endtask

  // Called at a negedge; returns at the negedge inside RESP.
  task automatic do_op(input logic [2:0] cmd, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                       input logic [AW-1:0] rs2, output int acc_cyc);
    logic [9:0]    exp;
    logic [DW-1:0] a_exp, b_exp;
    int w = 0;
    ld_en = 1'b0;
    in_cmd = cmd; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_valid = 1'b1;
    #1;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      #1;
      w++;
    end
    check("accept_ready", in_ready, 1);
    a_exp = model_rf[rs1];
    b_exp = model_rf[rs2];
    exp   = alu_model(cmd, a_exp, b_exp);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    sb_q.push_back(exp);
    model_rf[rd] = exp[7:0];
    @(negedge clk);
    in_valid = 1'b0;
    check("issue_a", alu_a, a_exp);
    check("issue_b", alu_b, b_exp);
    check("issue_cmd", alu_cmd, cmd);
    check("issue_busy", busy, 1);
    check("issue_in_ready", in_ready, 0);
    check("issue_out_valid", out_valid, 0);
    @(negedge clk);
    check("capture_out_valid", out_valid, 0);
    check("capture_data", out_data, exp[7:0]);
    @(negedge clk);
    check("resp_out_valid", out_valid, 1);
  endtask

  int acc1, acc2, dummy;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    in_valid = 1'b0; in_cmd = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) model_rf[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_cmd", alu_cmd, 0);
    check("rst_out", {out_c, out_z, out_data}, 0);
    @(negedge clk);

    // A3 + 65 = 108: y=08, c=1, z=0, written to reg2
    do_load(2'd0, 8'hA3);
    do_load(2'd1, 8'h65);
    do_op(3'b000, 2'd2, 2'd0, 2'd1, dummy);
    check("t1_data", out_data, 8'h08);
    check("t1_c", out_c, 1);
    check("t1_z", out_z, 0);
    @(negedge clk);
    check("t1_done_busy", busy, 0);
    // reg2 readback through alu_a; xor exercises cmd passthrough
    do_op(3'b101, 2'd3, 2'd2, 2'd0, dummy);
    check("t1_reg2", alu_a, 8'h08);
    wait_idle();

    // F0 + 10 = 100: zero result with carry, held for 5 cycles
    do_load(2'd0, 8'hF0);
    do_load(2'd1, 8'h10);
    out_ready = 1'b0;
    do_op(3'b000, 2'd1, 2'd0, 2'd1, dummy);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, 8'h00);
      check("hold_z", out_z, 1);
      check("hold_c", out_c, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_busy", busy, 1);
      ld_en = (i == 0); ld_addr = 2'd0; ld_data = 8'h55;
      @(negedge clk);
    end
    ld_en = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("hold_release_valid", out_valid, 0);
    check("hold_release_busy", busy, 0);
    // load during RESP must not have touched reg0 (still F0); reg1 now 00
    do_op(3'b000, 2'd2, 2'd0, 2'd1, dummy);
    check("ld_ignored_reg0", alu_a, 8'hF0);
    check("rd_eq_rs_reg1", alu_b, 8'h00);
    wait_idle();

    // load and request in the same IDLE cycle
    ld_en = 1'b1; ld_addr = 2'd3; ld_data = 8'h3C;
    in_valid = 1'b1; in_cmd = 3'b000; in_rd = 2'd0; in_rs1 = 2'd3; in_rs2 = 2'd1;
    #1;
    check("ld_vs_op_in_ready", in_ready, 0);
    @(negedge clk);
    model_rf[3] = 8'h3C;
    check("ld_vs_op_not_accepted", busy, 0);
    do_op(3'b000, 2'd0, 2'd3, 2'd1, dummy);
    check("ld_vs_op_loaded", alu_a, 8'h3C);
    wait_idle();

    // reset in CAPTURE
    do_load(2'd2, 8'h77);
    in_valid = 1'b1; in_cmd = 3'b000; in_rd = 2'd3; in_rs1 = 2'd2; in_rs2 = 2'd2;
    @(negedge clk);
    in_valid = 1'b0;
    check("rstmid_issue_busy", busy, 1);
    @(negedge clk);
    check("rstmid_capture_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    hs_cnt = 0;
    for (int i = 0; i < 4; i++) model_rf[i] = '0;
    check("rstmid_out_valid", out_valid, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_alu_a", alu_a, 0);
    check("rstmid_out", {out_c, out_z, out_data}, 0);
    repeat (2) @(negedge clk);
    check("rstmid_still_idle", busy, 0);

    // back-to-back ops, all registers expected 0
    do_op(3'b000, 2'd2, 2'd0, 2'd1, acc1);
    do_op(3'b000, 2'd0, 2'd2, 2'd3, acc2);
    check("b2b_gap", acc2 - acc1, 4);
    @(negedge clk);
`ifdef ALU_OP_COUNT_EN
    check("op_count_two", op_count, 2);
    do_load(2'd0, 8'h01);
    do_load(2'd1, 8'h02);
    for (int i = 0; i < 256; i++) begin
      do_op(3'b000, 2'd1, 2'd0, 2'd1, dummy);
    end
    @(negedge clk);
    check("op_count_sat", op_count, 8'hFF);
    check("op_count_hs_seen", (hs_cnt >= 255), 1);
`endif
    wait_idle();
    check("sb_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
